// File: rtl/cr_huf_comp_lz_symbol_gen_if.sv
// cr_huf_comp_lz_symbol_gen_if: byte-in / symbol-out bundle for the run-length LZ77 symbol generator
//   in_valid/in_data/in_last/in_ready   : raw byte stream with frame-end flag
//   sym_valid/sym_ready                 : registered symbol handshake
//   sym_type/sym_literal/sym_len/sym_offset/sym_last : literal (type 0) or match (type 1) payload
//   frame_sym_count                     : symbols in the last completed frame (saturating)
interface cr_huf_comp_lz_symbol_gen_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        sym_valid;
    logic        sym_ready;
    logic        sym_type;
    logic [7:0]  sym_literal;
    logic [8:0]  sym_len;
    logic [11:0] sym_offset;
    logic        sym_last;
    logic [15:0] frame_sym_count;
    modport master (
        input  in_valid, in_data, in_last, sym_ready,
        output in_ready, sym_valid, sym_type, sym_literal, sym_len, sym_offset, sym_last, frame_sym_count
    );
    modport slave (
        output in_valid, in_data, in_last, sym_ready,
        input  in_ready, sym_valid, sym_type, sym_literal, sym_len, sym_offset, sym_last, frame_sym_count
    );
endinterface

// File: rtl/cr_huf_comp_lz_symbol_gen.sv
// cr_huf_comp_lz_symbol_gen: turns a byte stream into literal / distance-1 match symbols (run-length LZ77)
//   clk, rst : clock, asynchronous active-high reset
//   bus      : master side of cr_huf_comp_lz_symbol_gen_if (byte input, registered symbol output)
module cr_huf_comp_lz_symbol_gen #(
    parameter int MIN_MATCH = 3,
    parameter int MAX_MATCH = 258
) (
    input logic clk,
    input logic rst,
    cr_huf_comp_lz_symbol_gen_if.master bus
);
    localparam logic [8:0] MINL = 9'(MIN_MATCH);
    localparam logic [8:0] MAXL = 9'(MAX_MATCH);
    typedef enum logic [2:0] {IDLE, RUN, FLUSH_MATCH, FLUSH_LIT, NEW_LIT, END} state_t;
    typedef struct packed {
        logic       typ;
        logic       last;
        logic [8:0] len;
        logic [7:0] lit;
    } sym_t;
    function automatic sym_t lit_sym(input logic [7:0] b, input logic l);
        return '{typ: 1'b0, last: l, len: 9'd0, lit: b};
    endfunction
    function automatic sym_t match_sym(input logic [8:0] n, input logic l);
        return '{typ: 1'b1, last: l, len: n, lit: 8'd0};
    endfunction
    state_t      state;
    sym_t        out;
    logic        out_valid;
    logic [7:0]  prev;
    logic [7:0]  hold_data;
    logic        hold_last;
    logic        fin;
    logic [8:0]  rep;
    logic [1:0]  pend_lit;
    logic [15:0] cnt;
    logic [15:0] frame_cnt;
    logic        can_load;
    logic        take;
    logic        same;
    logic [8:0]  rep_inc;
    assign can_load = !out_valid | bus.sym_ready;
    assign bus.in_ready = !rst & (state == IDLE | state == RUN) & can_load;
    assign take = bus.in_valid & bus.in_ready;
    assign same = bus.in_data == prev;
    assign rep_inc = rep + 9'd1;
    assign bus.sym_valid = out_valid;
    assign bus.sym_type = out.typ;
    assign bus.sym_literal = out.lit;
    assign bus.sym_len = out.len;
    assign bus.sym_offset = {11'd0, out.typ};
    assign bus.sym_last = out.last;
    assign bus.frame_sym_count = frame_cnt;
    // fin marks a frame whose last byte extended the run: the flush itself carries sym_last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            prev      <= 8'd0;
            hold_data <= 8'd0;
            hold_last <= 1'b0;
            fin       <= 1'b0;
            rep       <= 9'd0;
            pend_lit  <= 2'd0;
            cnt       <= 16'd0;
            frame_cnt <= 16'd0;
        end else begin
            if (out_valid & bus.sym_ready) cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            if (can_load) out_valid <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    out_valid <= 1'b1;
                    out       <= lit_sym(bus.in_data, bus.in_last);
                    prev      <= bus.in_data;
                    rep       <= 9'd0;
                    state     <= bus.in_last ? END : RUN;
                end
                RUN: if (take) begin
                    if (same && rep_inc == MAXL) begin
                        out_valid <= 1'b1;
                        out       <= match_sym(MAXL, bus.in_last);
                        rep       <= 9'd0;
                        state     <= bus.in_last ? END : RUN;
                    end else if (same && bus.in_last) begin
                        rep      <= rep_inc;
                        fin      <= 1'b1;
                        pend_lit <= rep_inc[1:0];
                        state    <= (rep_inc >= MINL) ? FLUSH_MATCH : FLUSH_LIT;
                    end else if (same) begin
                        rep <= rep_inc;
                    end else if (rep == 9'd0) begin
                        // nothing to flush: the new byte is a run head right away
                        out_valid <= 1'b1;
                        out       <= lit_sym(bus.in_data, bus.in_last);
                        prev      <= bus.in_data;
                        state     <= bus.in_last ? END : RUN;
                    end else begin
                        hold_data <= bus.in_data;
                        hold_last <= bus.in_last;
                        fin       <= 1'b0;
                        pend_lit  <= rep[1:0];
                        state     <= (rep >= MINL) ? FLUSH_MATCH : FLUSH_LIT;
                    end
                end
                FLUSH_MATCH: if (can_load) begin
                    out_valid <= 1'b1;
                    out       <= match_sym(rep, fin);
                    state     <= fin ? END : NEW_LIT;
                end
                FLUSH_LIT: if (can_load) begin
                    out_valid <= 1'b1;
                    out       <= lit_sym(prev, fin & (pend_lit == 2'd1));
                    pend_lit  <= pend_lit - 2'd1;
                    if (pend_lit == 2'd1) state <= fin ? END : NEW_LIT;
                end
                NEW_LIT: if (can_load) begin
                    out_valid <= 1'b1;
                    out       <= lit_sym(hold_data, hold_last);
                    prev      <= hold_data;
                    rep       <= 9'd0;
                    state     <= hold_last ? END : RUN;
                end
                END: if (out_valid & bus.sym_ready) begin
                    frame_cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    cnt       <= 16'd0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cr_huf_comp_lz_symbol_gen.sv
// tb_cr_huf_comp_lz_symbol_gen: directed and reconstruction checks for cr_huf_comp_lz_symbol_gen
module tb_cr_huf_comp_lz_symbol_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   rmode = 0;
    logic [7:0]  stim[$];
    logic [30:0] exp_q[$];
    logic [30:0] got[$];
    logic [30:0] held;
    logic        stalled = 1'b0;

    always #5 clk = ~clk;

    cr_huf_comp_lz_symbol_gen_if bus ();
    cr_huf_comp_lz_symbol_gen dut (.clk(clk), .rst(rst), .bus(bus));

    // symbol word: {type, last, len[8:0], offset[11:0], literal[7:0]}
    function automatic logic [30:0] L(input logic [7:0] b, input logic l);
        return {1'b0, l, 9'd0, 12'd0, b};
    endfunction
    function automatic logic [30:0] M(input logic [8:0] n, input logic l);
        return {1'b1, l, n, 12'd1, 8'd0};
    endfunction
    function automatic logic [30:0] cur_sym();
        return {bus.sym_type, bus.sym_last, bus.sym_len, bus.sym_offset, bus.sym_literal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.sym_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : 1'b0;
    end

    always @(negedge clk) begin
        if (!rst && bus.sym_valid && bus.sym_ready) got.push_back(cur_sym());
        if (!rst && stalled) chk("stall_hold", {bus.sym_valid, cur_sym()}, {1'b1, held});
        stalled = !rst && bus.sym_valid && !bus.sym_ready;
        held = cur_sym();
    end

    task automatic send(input logic [7:0] b, input logic last);
        int  n = 0;
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 1000);
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'(n), 32'd0);
    endtask

    task automatic send_stim();
        for (int i = 0; i < stim.size(); i++) send(stim[i], i == stim.size() - 1);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!(got.size() > 0 && got[got.size()-1][29]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done", 32'(n < 20000), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string tag);
        send_stim();
        wait_frame();
        chk({tag, "_nsym"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(exp_q[i]));
        chk({tag, "_count"}, 32'(bus.frame_sym_count), 32'(exp_q.size()));
        got.delete();
        stim.delete();
    endtask

    task automatic add_run(input logic [7:0] b, input int n);
        repeat (n) stim.push_back(b);
    endtask

    initial begin
        logic [7:0] outb[$];
        logic [7:0] ref_b[$];
        int bad;
        int mism;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.in_last  = 1'b0;
        bus.sym_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.sym_valid), 32'd0);
        chk("rst_payload", 32'(cur_sym()), 32'd0);
        chk("rst_count", 32'(bus.frame_sym_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        add_run(8'h41, 1);
        exp_q = '{L(8'h41, 1'b1)};
        chk_frame("single_A");

        add_run(8'h55, 10); add_run(8'h66, 1);
        exp_q = '{L(8'h55, 1'b0), M(9'd9, 1'b0), L(8'h66, 1'b1)};
        chk_frame("run10");

        add_run(8'h42, 2); add_run(8'h43, 1);
        exp_q = '{L(8'h42, 1'b0), L(8'h42, 1'b0), L(8'h43, 1'b1)};
        chk_frame("BBC");

        add_run(8'h43, 3);
        exp_q = '{L(8'h43, 1'b0), L(8'h43, 1'b0), L(8'h43, 1'b1)};
        chk_frame("CCC_last");

        add_run(8'h44, 4);
        exp_q = '{L(8'h44, 1'b0), M(9'd3, 1'b1)};
        chk_frame("DDDD_last");

        add_run(8'h41, 1); add_run(8'h42, 1); add_run(8'h41, 1); add_run(8'h42, 1);
        exp_q = '{L(8'h41, 1'b0), L(8'h42, 1'b0), L(8'h41, 1'b0), L(8'h42, 1'b1)};
        chk_frame("ABAB");

        add_run(8'h00, 300);
        exp_q = '{L(8'h00, 1'b0), M(9'd258, 1'b0), M(9'd41, 1'b1)};
        chk_frame("run300");

        add_run(8'h00, 260);
        exp_q = '{L(8'h00, 1'b0), M(9'd258, 1'b0), L(8'h00, 1'b1)};
        chk_frame("run260");

        add_run(8'h07, 259);
        exp_q = '{L(8'h07, 1'b0), M(9'd258, 1'b1)};
        chk_frame("run259_max_last");

        rmode = 2;
        @(posedge clk);
        #1;
        send(8'h51, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_valid", 32'(bus.sym_valid), 32'd1);
        chk("stall_lit", 32'(bus.sym_literal), 32'h51);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.sym_valid), 32'd0);
        chk("midrst_payload", 32'(cur_sym()), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_count", 32'(bus.frame_sym_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rmode = 0;
        got.delete();
        @(posedge clk);
        #1;
        add_run(8'h41, 1); add_run(8'h41, 1); add_run(8'h5A, 1);
        exp_q = '{L(8'h41, 1'b0), L(8'h41, 1'b0), L(8'h5A, 1'b1)};
        chk_frame("after_rst");

        rmode = 1;
        while (stim.size() < 1024) begin
            logic [7:0] b;
            int n;
            b = 8'($urandom_range(0, 3));
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 400) : $urandom_range(1, 6);
            repeat (n) if (stim.size() < 1024) stim.push_back(b);
        end
        ref_b = stim;
        send_stim();
        wait_frame();
        bad = 0;
        foreach (got[i]) begin
            if (got[i][29] != (i == got.size() - 1)) bad++;
            if (got[i][30]) begin
                if (got[i][28:20] < 9'd3 || got[i][28:20] > 9'd258 || got[i][19:8] != 12'd1 || got[i][7:0] != 8'd0 || outb.size() == 0) bad++;
                else repeat (int'(got[i][28:20])) outb.push_back(outb[outb.size()-1]);
            end else begin
                if (got[i][28:8] != 21'd0) bad++;
                outb.push_back(got[i][7:0]);
            end
        end
        mism = 0;
        for (int i = 0; i < 1024; i++) if (i >= outb.size() || outb[i] !== ref_b[i]) mism++;
        chk("rand_len", 32'(outb.size()), 32'd1024);
        chk("rand_bytes", 32'(mism), 32'd0);
        chk("rand_syms", 32'(bad), 32'd0);
        chk("rand_count", 32'(bus.frame_sym_count), 32'(got.size()));
        got.delete();
        stim.delete();
        rmode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
